// File: rtl/wb_pkg.sv
// Shared Wishbone B4 definitions for the SRAM slave: cycle/burst type codes,
// FSM state encoding and the burst wrap-mask helper.
package wb_pkg;

   localparam logic [2:0] CTI_CLASSIC = 3'b000;
   localparam logic [2:0] CTI_CONST   = 3'b001;
   localparam logic [2:0] CTI_INCR    = 3'b010;
   localparam logic [2:0] CTI_END     = 3'b111;

   localparam logic [1:0] BTE_LINEAR  = 2'b00;
   localparam logic [1:0] BTE_WRAP4   = 2'b01;
   localparam logic [1:0] BTE_WRAP8   = 2'b10;
   localparam logic [1:0] BTE_WRAP16  = 2'b11;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP,
      BURST
   } wb_state_e;

   // Word-index bits that wrap for a given burst type; 0 means linear.
   function automatic logic [3:0] bte_mask(input logic [1:0] bte);
      case (bte)
         BTE_WRAP4:  bte_mask = 4'h3;
         BTE_WRAP8:  bte_mask = 4'h7;
         BTE_WRAP16: bte_mask = 4'hF;
         default:    bte_mask = 4'h0;
      endcase
   endfunction

endpackage

// File: rtl/wb_sram_array.sv
// Single-port synchronous RAM with per-byte write mask and registered read.
// Read returns the pre-write contents on a same-address write.
module wb_sram_array
   import wb_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int DEPTH      = 4096,
   parameter int ADDR_WIDTH = 12
) (
   input  logic                    clk_i,
   input  logic                    we_i,
   input  logic [ADDR_WIDTH-1:0]   adr_i,
   input  logic [DATA_WIDTH/8-1:0] sel_i,
   input  logic [DATA_WIDTH-1:0]   dat_i,
   output logic [DATA_WIDTH-1:0]   dat_o
);

   localparam int unsigned NB = DATA_WIDTH / 8;

   logic [DATA_WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int unsigned b = 0; b < NB; b++) begin
            if (sel_i[b]) mem[adr_i][8*b +: 8] <= dat_i[8*b +: 8];
         end
      end
      dat_o <= mem[adr_i];
   end

endmodule

// File: rtl/wb_sram.sv
// Wishbone B4 classic slave over a byte-masked SRAM with configurable read latency.
// Define WB_SRAM_BURST_EN to add registered-feedback incrementing/wrapping bursts.
module wb_sram
   import wb_pkg::*;
#(
   parameter logic [31:0] BASE_ADDRESS = 32'h0,
   parameter int          SIZE_BYTES   = 16384,
   parameter int          DATA_WIDTH   = 32,
   parameter int          READ_LATENCY = 1
) (
   input  logic                    clk_i,
   input  logic                    rst_i,
   input  logic                    cyc_i,
   input  logic                    stb_i,
   input  logic                    we_i,
   input  logic [31:0]             adr_i,
   input  logic [DATA_WIDTH/8-1:0] sel_i,
   input  logic [DATA_WIDTH-1:0]   dat_i,
`ifdef WB_SRAM_BURST_EN
   input  logic [2:0]              cti_i,
   input  logic [1:0]              bte_i,
`endif
   output logic [DATA_WIDTH-1:0]   dat_o,
   output logic                    ack_o,
   output logic                    err_o,
   output logic                    rty_o
);

   localparam int          NB       = DATA_WIDTH / 8;
   localparam int          OFF      = $clog2(NB);
   localparam int          DEPTH    = SIZE_BYTES / NB;
   localparam int          AW       = $clog2(DEPTH);
   localparam logic [31:0] WIN_MASK = 32'(SIZE_BYTES - 1);
   localparam logic [31:0] MIS_MASK = 32'(NB - 1);

   wb_state_e             state;
   logic [1:0]            cnt;
   logic [AW-1:0]         r_idx;
   logic                  r_we;
   logic                  r_mis;
   logic [NB-1:0]         r_sel;
   logic [DATA_WIDTH-1:0] r_dat;

   logic                  hit;
   logic                  in_mis;
   logic [AW-1:0]         in_idx;

   logic                  ram_we;
   logic [AW-1:0]         ram_adr;
   logic [NB-1:0]         ram_sel;
   logic [DATA_WIDTH-1:0] ram_dat;
   logic [DATA_WIDTH-1:0] ram_q;

   // BASE_ADDRESS is window-aligned, so the word index is a plain bit slice.
   assign hit    = cyc_i && stb_i && ((adr_i & ~WIN_MASK) == BASE_ADDRESS);
   assign in_mis = |(adr_i & MIS_MASK);
   assign in_idx = adr_i[OFF +: AW];

`ifdef WB_SRAM_BURST_EN
   logic                  bst;
   logic [1:0]            r_bte;
   logic [AW-1:0]         inc_idx;
   logic [AW-1:0]         wrap_m;
   logic [AW-1:0]         nxt_idx;

   assign inc_idx = r_idx + AW'(1);
   assign wrap_m  = (r_bte == BTE_LINEAR) ? '1 : AW'(bte_mask(r_bte));
   assign nxt_idx = (r_idx & ~wrap_m) | (inc_idx & wrap_m);
`endif

   // With READ_LATENCY=1 the accepting edge is also the commit/read edge, so
   // the RAM is driven straight from the bus while IDLE.
   always_comb begin
      ram_we  = 1'b0;
      ram_adr = r_idx;
      ram_sel = r_sel;
      ram_dat = r_dat;
      if (state == IDLE) begin
         ram_adr = in_idx;
         ram_sel = sel_i;
         ram_dat = dat_i;
         ram_we  = hit && we_i && !in_mis && (READ_LATENCY == 1);
      end else if (state == WAIT) begin
         ram_we  = cyc_i && (cnt == '0) && r_we && !r_mis;
      end
`ifdef WB_SRAM_BURST_EN
      else if (state == BURST && ack_o && cyc_i && stb_i && r_we) begin
         ram_we  = 1'b1;
         ram_sel = sel_i;
         ram_dat = dat_i;
      end else if (bst && ack_o) begin
         ram_adr = nxt_idx;
      end
`endif
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state <= IDLE;
         cnt   <= '0;
         r_idx <= '0;
         r_we  <= 1'b0;
         r_mis <= 1'b0;
         r_sel <= '0;
         r_dat <= '0;
         ack_o <= 1'b0;
         err_o <= 1'b0;
`ifdef WB_SRAM_BURST_EN
         bst   <= 1'b0;
         r_bte <= BTE_LINEAR;
`endif
      end else begin
         ack_o <= 1'b0;
         err_o <= 1'b0;
         case (state)
            IDLE: if (hit) begin
               r_idx <= in_idx;
               r_we  <= we_i;
               r_mis <= in_mis;
               r_sel <= sel_i;
               r_dat <= dat_i;
`ifdef WB_SRAM_BURST_EN
               bst   <= (READ_LATENCY == 1) && (cti_i == CTI_INCR) && !in_mis;
               r_bte <= bte_i;
`endif
               if (READ_LATENCY == 1) begin
                  state <= RESP;
                  ack_o <= !in_mis;
                  err_o <= in_mis;
               end else begin
                  state <= WAIT;
                  cnt   <= 2'(READ_LATENCY - 2);
               end
            end
            WAIT: begin
               if (!cyc_i) begin
                  state <= IDLE;
               end else if (cnt == '0) begin
                  state <= RESP;
                  ack_o <= !r_mis;
                  err_o <= r_mis;
               end else begin
                  cnt <= cnt - 2'd1;
               end
            end
`ifdef WB_SRAM_BURST_EN
            // The first burst beat is acked from RESP; later beats from BURST.
            RESP, BURST: begin
               if (state == RESP && !bst) begin
                  state <= IDLE;
               end else if (!cyc_i) begin
                  state <= IDLE;
                  bst   <= 1'b0;
               end else if (!stb_i) begin
                  state <= BURST;
               end else if (ack_o) begin
                  if (cti_i == CTI_END) begin
                     state <= IDLE;
                     bst   <= 1'b0;
                  end else if (r_bte == BTE_LINEAR && r_idx == '1) begin
                     state <= RESP;
                     bst   <= 1'b0;
                     err_o <= 1'b1;
                  end else begin
                     state <= BURST;
                     r_idx <= nxt_idx;
                     ack_o <= 1'b1;
                  end
               end else begin
                  state <= BURST;
                  ack_o <= 1'b1;
               end
            end
`else
            RESP: state <= IDLE;
`endif
            default: state <= IDLE;
         endcase
      end
   end

   wb_sram_array #(
      .DATA_WIDTH (DATA_WIDTH),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW)
   ) u_array (
      .clk_i (clk_i),
      .we_i  (ram_we),
      .adr_i (ram_adr),
      .sel_i (ram_sel),
      .dat_i (ram_dat),
      .dat_o (ram_q)
   );

   assign dat_o = ack_o ? ram_q : '0;
   assign rty_o = 1'b0;

endmodule

// File: tb/tb_wb_sram.sv
// Bench for wb_sram: one READ_LATENCY=1 and one READ_LATENCY=3 instance on a
// shared bus with separate cyc lines; responses checked through a scoreboard.
module tb_wb_sram;

   localparam logic [31:0] BASE = 32'h0002_0000;

   typedef struct {
      bit          d3;
      bit          we;
      logic [31:0] off;
      logic [3:0]  sel;
      logic [31:0] dat;
      bit          resp;
      bit          err;
      logic [31:0] rdat;
      int          lat;
   } vec_t;

   typedef struct {
      bit          err;
      bit          cmp;
      logic [31:0] dat;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cyc1 = 1'b0, cyc3 = 1'b0, stb = 1'b0, we = 1'b0;
   logic [31:0] adr = '0, dat_w = '0;
   logic [3:0]  sel = '0;
   logic [31:0] dat1, dat3;
   logic        ack1, ack3, err1, err3, rty1, rty3;
   logic        r_ack, r_err;
   logic [31:0] r_dat;
`ifdef WB_SRAM_BURST_EN
   logic [2:0]  cti = 3'b000;
   logic [1:0]  bte = 2'b00;
`endif

   int   checks = 0;
   int   errors = 0;
   exp_t sbq[$];
   vec_t vt[20];

   always #5 clk = ~clk;

   assign r_ack = ack1 | ack3;
   assign r_err = err1 | err3;
   assign r_dat = dat1 | dat3;

   wb_sram #(.BASE_ADDRESS(BASE), .SIZE_BYTES(16384), .DATA_WIDTH(32), .READ_LATENCY(1)) dut1 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc1), .stb_i(stb), .we_i(we), .adr_i(adr),
      .sel_i(sel), .dat_i(dat_w),
`ifdef WB_SRAM_BURST_EN
      .cti_i(cti), .bte_i(bte),
`endif
      .dat_o(dat1), .ack_o(ack1), .err_o(err1), .rty_o(rty1));

   wb_sram #(.BASE_ADDRESS(BASE), .SIZE_BYTES(16384), .DATA_WIDTH(32), .READ_LATENCY(3)) dut3 (
      .clk_i(clk), .rst_i(rst), .cyc_i(cyc3), .stb_i(stb), .we_i(we), .adr_i(adr),
      .sel_i(sel), .dat_i(dat_w),
`ifdef WB_SRAM_BURST_EN
      .cti_i(cti), .bte_i(bte),
`endif
      .dat_o(dat3), .ack_o(ack3), .err_o(err3), .rty_o(rty3));

   function automatic void chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endfunction

   always @(negedge clk) begin
      exp_t e;
      if (!rst && (r_ack || r_err)) begin
         if (sbq.size() == 0) begin
            chk("sb_unexpected", {30'b0, r_ack, r_err}, 32'h0);
         end else begin
            e = sbq.pop_front();
            chk("sb_err", {31'b0, r_err}, {31'b0, e.err});
            chk("sb_ack", {31'b0, r_ack}, {31'b0, !e.err});
            if (e.cmp) chk("sb_dat", r_dat, e.dat);
         end
      end
   end

   task automatic xfer(input bit d3, input bit w, input logic [31:0] a, input logic [3:0] s,
                       input logic [31:0] d, output int lat);
      @(negedge clk);
      cyc1 = !d3; cyc3 = d3; stb = 1'b1; we = w; adr = a; sel = s; dat_w = d;
      lat = 0;
      for (int k = 1; k <= 8; k++) begin
         @(negedge clk);
         if (r_ack || r_err) begin
            lat = k;
            break;
         end
      end
      cyc1 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
   endtask

   task automatic run_vec(input vec_t v, input string name);
      int   lat;
      exp_t e;
      if (v.resp) begin
         e.err = v.err;
         e.cmp = !v.we || v.err;
         e.dat = v.err ? 32'h0 : v.rdat;
         sbq.push_back(e);
      end
      xfer(v.d3, v.we, BASE + v.off, v.sel, v.dat, lat);
      chk({name, "_lat"}, lat, v.resp ? v.lat : 0);
      @(negedge clk);
      chk({name, "_1cyc"}, {31'b0, r_ack | r_err}, 32'h0);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      vec_t v;
      int   nacks, gaps;

      //        d3    we    off            sel   dat           resp  err   rdat          lat
      vt[0]  = '{1'b0, 1'b1, 32'h10,        4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        1};
      vt[1]  = '{1'b0, 1'b0, 32'h10,        4'hF, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1};
      vt[2]  = '{1'b0, 1'b1, 32'h20,        4'hF, 32'hFFFFFFFF, 1'b1, 1'b0, 32'h0,        1};
      vt[3]  = '{1'b0, 1'b1, 32'h20,        4'h5, 32'h11223344, 1'b1, 1'b0, 32'h0,        1};
      vt[4]  = '{1'b0, 1'b0, 32'h20,        4'hF, 32'h0,        1'b1, 1'b0, 32'hFF22FF44, 1};
      vt[5]  = '{1'b0, 1'b1, 32'h12,        4'hF, 32'hAAAAAAAA, 1'b1, 1'b1, 32'h0,        1};
      vt[6]  = '{1'b0, 1'b0, 32'h10,        4'hF, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1};
      vt[7]  = '{1'b0, 1'b1, 32'h10,        4'h0, 32'h55555555, 1'b1, 1'b0, 32'h0,        1};
      vt[8]  = '{1'b0, 1'b0, 32'h10,        4'hF, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 1};
      vt[9]  = '{1'b0, 1'b1, 32'h3FFC,      4'hF, 32'h0BADF00D, 1'b1, 1'b0, 32'h0,        1};
      vt[10] = '{1'b0, 1'b0, 32'h3FFC,      4'hF, 32'h0,        1'b1, 1'b0, 32'h0BADF00D, 1};
      vt[11] = '{1'b0, 1'b1, 32'h0,         4'hF, 32'h12345678, 1'b1, 1'b0, 32'h0,        1};
      vt[12] = '{1'b0, 1'b1, 32'h4000,      4'hF, 32'hCAFEBABE, 1'b0, 1'b0, 32'h0,        0};
      vt[13] = '{1'b0, 1'b1, 32'hFFFFFFFC,  4'hF, 32'hCAFEBABE, 1'b0, 1'b0, 32'h0,        0};
      vt[14] = '{1'b0, 1'b0, 32'h0,         4'hF, 32'h0,        1'b1, 1'b0, 32'h12345678, 1};
      vt[15] = '{1'b0, 1'b0, 32'h3FFC,      4'hF, 32'h0,        1'b1, 1'b0, 32'h0BADF00D, 1};
      vt[16] = '{1'b0, 1'b0, 32'h11,        4'hF, 32'h0,        1'b1, 1'b1, 32'h0,        1};
      vt[17] = '{1'b1, 1'b1, 32'h10,        4'hF, 32'hDEADBEEF, 1'b1, 1'b0, 32'h0,        3};
      vt[18] = '{1'b1, 1'b0, 32'h10,        4'hF, 32'h0,        1'b1, 1'b0, 32'hDEADBEEF, 3};
      vt[19] = '{1'b1, 1'b1, 32'h16,        4'hF, 32'h1,        1'b1, 1'b1, 32'h0,        3};

      repeat (3) @(negedge clk);
      chk("rst_outs", {28'b0, ack1 | ack3, err1 | err3, rty1 | rty3, 1'b0}, 32'h0);
      chk("rst_dat", dat1 | dat3, 32'h0);
      rst = 1'b0;

      for (int i = 0; i < 20; i++) run_vec(vt[i], $sformatf("v%0d", i));

      // Abort during WAIT on the latency-3 slave: no response, no write.
      @(negedge clk);
      cyc3 = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h10; sel = 4'hF; dat_w = 32'h77777777;
      @(negedge clk);
      cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
      gaps = 0;
      for (int k = 0; k < 6; k++) begin
         @(negedge clk);
         if (ack3 || err3) gaps++;
      end
      chk("abort_noresp", gaps, 0);
      run_vec(vt[18], "abort_rb");

      // Reset landing mid-WAIT drops the write.
      @(negedge clk);
      cyc3 = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE + 32'h10; sel = 4'hF; dat_w = 32'h99999999;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_resp", {30'b0, ack3, err3}, 32'h0);
      cyc3 = 1'b0; stb = 1'b0; we = 1'b0;
      rst = 1'b0;
      run_vec(vt[18], "rst_rb");

      // Reset asserted inside the ack cycle clears outputs without a clock edge.
      @(negedge clk);
      cyc1 = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h10; sel = 4'hF;
      @(posedge clk);
      #2 rst = 1'b1;
      #1 chk("rst_async_ack", {31'b0, ack1}, 32'h0);
      chk("rst_async_dat", dat1, 32'h0);
      cyc1 = 1'b0; stb = 1'b0;
      @(negedge clk);
      rst = 1'b0;

`ifdef WB_SRAM_BURST_EN
      for (int i = 0; i < 8; i++) begin
         v = '{1'b0, 1'b1, 32'(i * 4), 4'hF, 32'hB000_0000 + 32'(i), 1'b1, 1'b0, 32'h0, 1};
         run_vec(v, $sformatf("bw%0d", i));
      end
      for (int i = 0; i < 8; i++) begin
         exp_t e;
         e.err = 1'b0; e.cmp = 1'b1; e.dat = 32'hB000_0000 + 32'((6 + i) % 8);
         sbq.push_back(e);
      end
      @(negedge clk);
      cyc1 = 1'b1; stb = 1'b1; we = 1'b0; adr = BASE + 32'h18; sel = 4'hF;
      cti = 3'b010; bte = 2'b10;
      nacks = 0; gaps = 0;
      for (int k = 0; k < 20 && nacks < 8; k++) begin
         @(negedge clk);
         if (ack1) begin
            nacks++;
            adr = BASE + 32'(((6 + nacks) % 8) * 4);
            cti = (nacks == 7) ? 3'b111 : ((nacks == 8) ? 3'b000 : 3'b010);
         end else begin
            gaps++;
         end
      end
      chk("burst_beats", nacks, 8);
      chk("burst_gaps", gaps, 0);
      @(negedge clk);
      chk("burst_end_ack", {31'b0, ack1}, 32'h0);
      cyc1 = 1'b0; stb = 1'b0; cti = 3'b000; bte = 2'b00;
      repeat (2) @(negedge clk);
`endif

      chk("rty_tied", {31'b0, rty1 | rty3}, 32'h0);
      chk("sb_drain", sbq.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
